ahb_lite_master: RTL and testbench

Single-outstanding AHB-lite style master bridge sitting directly upstream of ram_top. It converts CPU load/store requests into AHB address and data phases. It also drives hsel, haddr, hwrite and hwdata into the RAM slave and returns hrdata/hresp to the CPU as a buffered response.
- Adds alignment checking and a bounded wait on hready so a hung slave cannot lock the core.

---
 rtl/ahb_lite_master_if.sv | 46 ++++
 rtl/ahb_lite_master.sv | 136 +++++++++++++
 tb/tb_ahb_lite_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if
//   Bundles the CPU request/response handshake and the AHB-lite bus signals
//   of ahb_lite_master into one interface.
//   master modport : bridge side (drives cpu_req_ready, cpu_rsp_*, h* outputs)
//   slave  modport : environment side (CPU + AHB slave)
//   Signals:
//     cpu_req_valid/ready/we/addr/wdata  CPU request channel
//     cpu_rsp_valid/ready/rdata/err/timeout  CPU response channel
//     haddr/hwrite/hsel/hwdata           AHB outputs to the slave
//     hready/hresp/hrdata                AHB inputs from the slave
interface ahb_lite_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req_valid;
   logic              cpu_req_ready;
   logic              cpu_req_we;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic [DATA_W-1:0] cpu_req_wdata;
   logic              cpu_rsp_valid;
   logic              cpu_rsp_ready;
   logic [DATA_W-1:0] cpu_rsp_rdata;
   logic              cpu_rsp_err;
   logic              cpu_rsp_timeout;
   logic [ADDR_W-1:0] haddr;
   logic              hwrite;
   logic              hsel;
   logic [DATA_W-1:0] hwdata;
   logic              hready;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;

   modport master (
      input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
      input  cpu_rsp_ready, hready, hresp, hrdata,
      output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
      output cpu_rsp_timeout, haddr, hwrite, hsel, hwdata
   );

   modport slave (
      output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
      output cpu_rsp_ready, hready, hresp, hrdata,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
      input  cpu_rsp_timeout, haddr, hwrite, hsel, hwdata
   );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   Single-outstanding bridge from CPU load/store requests to AHB-lite
//   address/data phases. Misaligned requests are rejected without bus
//   activity; a data phase stalled on hready for TIMEOUT cycles is forced
//   to an error so a hung slave cannot lock the core.
//   Ports:
//     clk   rising-edge system clock
//     rstn  asynchronous active-low reset
//     bus   ahb_lite_master_if.master (CPU request/response + AHB signals)
//   Parameters: ADDR_W, DATA_W (bus widths), TIMEOUT (1..255 wait cycles)
module ahb_lite_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rstn,
   ahb_lite_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   // Counter holds the number of wait cycles already seen; the TIMEOUT-th
   // wait cycle is therefore the one where it equals TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic [7:0]        wait_cnt;

   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;
   logic [ADDR_W-1:0] haddr_q;
   logic              hwrite_q;
   logic              hsel_q;
   logic [DATA_W-1:0] hwdata_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         lat_we        <= 1'b0;
         lat_wdata     <= '0;
         wait_cnt      <= '0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         haddr_q       <= '0;
         hwrite_q      <= 1'b0;
         hsel_q        <= 1'b0;
         hwdata_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cpu_req_valid) begin
                  lat_we      <= bus.cpu_req_we;
                  lat_wdata   <= bus.cpu_req_wdata;
                  req_ready_q <= 1'b0;
                  if (bus.cpu_req_addr[1:0] != 2'b00) begin
                     rsp_valid_q   <= 1'b1;
                     rsp_err_q     <= 1'b1;
                     rsp_timeout_q <= 1'b0;
                     rsp_rdata_q   <= '0;
                     state         <= RESP;
                  end else begin
                     // haddr register doubles as the latched request address
                     hsel_q   <= 1'b1;
                     hwrite_q <= bus.cpu_req_we;
                     haddr_q  <= bus.cpu_req_addr;
                     state    <= ADDR;
                  end
               end
            end
            ADDR: begin
               hsel_q   <= 1'b0;
               hwrite_q <= 1'b0;
               haddr_q  <= '0;
               hwdata_q <= lat_we ? lat_wdata : '0;
               wait_cnt <= '0;
               state    <= DATA;
            end
            DATA: begin
               if (bus.hready) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= bus.hresp;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= (!lat_we && !bus.hresp) ? bus.hrdata : '0;
                  hwdata_q      <= '0;
                  state         <= RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_rdata_q   <= '0;
                  hwdata_q      <= '0;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               if (bus.cpu_rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= '0;
                  req_ready_q   <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cpu_req_ready   = req_ready_q;
   assign bus.cpu_rsp_valid   = rsp_valid_q;
   assign bus.cpu_rsp_rdata   = rsp_rdata_q;
   assign bus.cpu_rsp_err     = rsp_err_q;
   assign bus.cpu_rsp_timeout = rsp_timeout_q;
   assign bus.haddr           = haddr_q;
   assign bus.hwrite          = hwrite_q;
   assign bus.hsel            = hsel_q;
   assign bus.hwdata          = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
//   Scoreboard bench for ahb_lite_master: the stimulus process plans each
//   transaction (request + slave wait/response behaviour), derives the
//   expected bus phases and CPU response from the bridge rules, and pushes
//   them into queues; a negedge monitor pops and compares.
module tb_ahb_lite_master;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ahb_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   bit hold_rsp = 1'b0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
      int unsigned vcyc;
   } rsp_t;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] hw;
      int unsigned acyc;
   } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // CPU response acceptance, randomly back-pressured unless held off
   initial begin
      bus.cpu_rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.cpu_rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor
   initial begin
      bit          seen = 1'b0;
      bit          hw_pend = 1'b0;
      int unsigned hw_cyc = 0;
      logic [31:0] hw_exp = '0;
      bit          rdy_pend = 1'b0;
      int unsigned rdy_cyc = 0;
      bus_t        b;
      rsp_t        r;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (rdy_pend && cyc == rdy_cyc) begin
               chk("req_ready_after_accept", bus.cpu_req_ready, 1'b1);
               rdy_pend = 1'b0;
            end
            if (hw_pend && cyc == hw_cyc) begin
               chk("hwdata", bus.hwdata, hw_exp);
               hw_pend = 1'b0;
            end
            if (bus.hsel) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_hsel: got hsel=1 with haddr %0h, required hsel=0", bus.haddr);
               end else begin
                  b = bus_q.pop_front();
                  chk("haddr", bus.haddr, b.addr);
                  chk("hwrite", bus.hwrite, b.we);
                  chk("hsel_cycle", cyc, b.acyc);
                  hw_pend = 1'b1;
                  hw_cyc  = cyc + 1;
                  hw_exp  = b.hw;
               end
            end
            if (bus.cpu_rsp_valid) begin
               if (rsp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: got rsp_valid=1, required 0");
               end else begin
                  r = rsp_q[0];
                  chk("rsp_rdata", bus.cpu_rsp_rdata, r.rdata);
                  chk("rsp_err", bus.cpu_rsp_err, r.err);
                  chk("rsp_timeout", bus.cpu_rsp_timeout, r.to);
                  chk("req_ready_in_resp", bus.cpu_req_ready, 1'b0);
                  chk("hwdata_after_data", bus.hwdata, 32'h0);
                  chk("hsel_in_resp", bus.hsel, 1'b0);
                  if (!seen) begin
                     chk("rsp_latency", cyc, r.vcyc);
                     seen = 1'b1;
                  end
                  if (bus.cpu_rsp_ready) begin
                     void'(rsp_q.pop_front());
                     seen     = 1'b0;
                     rdy_pend = 1'b1;
                     rdy_cyc  = cyc + 1;
                  end
               end
            end
         end else begin
            seen     = 1'b0;
            hw_pend  = 1'b0;
            rdy_pend = 1'b0;
         end
      end
   end

   task automatic finish_now();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.cpu_req_ready) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_ready: cpu_req_ready stayed 0 for 400 cycles, required 1");
      finish_now();
   endtask

   // One transaction: w = data-phase wait cycles the slave inserts before
   // hready=1 with response (hr, hd). Expected outcome from the bridge rules.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned w, input logic hr, input logic [31:0] hd);
      int unsigned a;
      bit aligned;
      bus_t b;
      rsp_t r;
      wait_ready();
      @(posedge clk);
      #1;
      a = cyc + 1;
      aligned = (addr[1:0] == 2'b00);
      if (!aligned) begin
         r = '{rdata: 32'h0, err: 1'b1, to: 1'b0, vcyc: a};
      end else begin
         b = '{addr: addr, we: we, hw: (we ? wdata : 32'h0), acyc: a};
         bus_q.push_back(b);
         if (w >= TO) r = '{rdata: 32'h0, err: 1'b1, to: 1'b1, vcyc: a + 1 + TO};
         else         r = '{rdata: ((!we && !hr) ? hd : 32'h0), err: hr, to: 1'b0, vcyc: a + 2 + w};
      end
      rsp_q.push_back(r);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_we    = we;
      bus.cpu_req_addr  = addr;
      bus.cpu_req_wdata = wdata;
      @(posedge clk);
      #1;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_we    = 1'($urandom);
      bus.cpu_req_addr  = $urandom;
      bus.cpu_req_wdata = $urandom;
      if (aligned) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(w); i++) begin
            bus.hready = 1'b0;
            bus.hresp  = 1'($urandom);
            bus.hrdata = $urandom;
            @(posedge clk);
            #1;
         end
         bus.hready = 1'b1;
         bus.hresp  = hr;
         bus.hrdata = hd;
         @(posedge clk);
         #1;
         bus.hready = 1'($urandom);
         bus.hresp  = 1'($urandom);
         bus.hrdata = $urandom;
      end
   endtask

   initial begin
      logic [31:0] ra;
      rstn = 1'b0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_we    = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_wdata = '0;
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hsel", bus.hsel, 1'b0);
      chk("reset_hwrite", bus.hwrite, 1'b0);
      chk("reset_haddr", bus.haddr, 32'h0);
      chk("reset_hwdata", bus.hwdata, 32'h0);
      chk("reset_rsp_valid", bus.cpu_rsp_valid, 1'b0);
      chk("reset_rsp_fields", {bus.cpu_rsp_err, bus.cpu_rsp_timeout, bus.cpu_rsp_rdata}, 34'h0);
      chk("reset_req_ready", bus.cpu_req_ready, 1'b1);
      rstn = 1'b1;

      run_txn(1'b1, 32'hF0F0_F0F0, 32'h1234_5678, 0, 1'b0, 32'hDEAD_BEEF);
      run_txn(1'b0, 32'hF0F0_F0F0, 32'h0, 0, 1'b0, 32'h1234_5678);
      run_txn(1'b0, 32'hF0F0_F0F1, 32'h0, 0, 1'b0, 32'h1234_5678);
      run_txn(1'b0, 32'h0000_0100, 32'h0, 3, 1'b1, 32'hAAAA_5555);
      run_txn(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 20, 1'b0, 32'h0);
      run_txn(1'b0, 32'h0000_0300, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);

      // Response back-pressure for 5 cycles
      hold_rsp = 1'b1;
      run_txn(1'b0, 32'h0000_0404, 32'h0, 1, 1'b0, 32'h5A5A_A5A5);
      begin
         bit got = 1'b0;
         for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus.cpu_rsp_valid;
         end
         chk("bp_rsp_seen", got, 1'b1);
      end
      repeat (5) @(negedge clk);
      hold_rsp = 1'b0;

      // Reset asserted during the data phase of a store
      wait_ready();
      @(posedge clk);
      #1;
      bus_q.push_back('{addr: 32'h0000_0800, we: 1'b1, hw: 32'h7777_1111, acyc: cyc + 1});
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_we    = 1'b1;
      bus.cpu_req_addr  = 32'h0000_0800;
      bus.cpu_req_wdata = 32'h7777_1111;
      bus.hready        = 1'b0;
      @(posedge clk);
      #1;
      bus.cpu_req_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
      #1;
      chk("midrst_hsel", bus.hsel, 1'b0);
      chk("midrst_hwdata", bus.hwdata, 32'h0);
      chk("midrst_haddr_hwrite", {bus.haddr, bus.hwrite}, 33'h0);
      chk("midrst_rsp", {bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.cpu_rsp_timeout, bus.cpu_rsp_rdata}, 35'h0);
      chk("midrst_req_ready", bus.cpu_req_ready, 1'b1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.hready = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         run_txn(1'($urandom), ra, $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2),
                 ($urandom_range(0, 4) == 0), $urandom);
      end

      wait_ready();
      repeat (2) @(negedge clk);
      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("bus_queue_drained", bus_q.size(), 0);
      finish_now();
   end
endmodule
